// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Receives a framed byte stream (LEN_HI, LEN_LO, LEN words high byte first, CHK)
// over valid/ready. Each assembled 16-bit word is written to the next sequential
// address. The core is held in reset until the frame's XOR checksum has been verified.
module imem_loader #(
   parameter int ADDR_WIDTH   = 11,
   parameter int MEMORY_DEPTH = 2048
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [15:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [11:0]           words_loaded
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      CHECK,
      DONE,
      ERROR
   } state_t;

   state_t      state;
   state_t      next_state;
   logic        accept;
   logic        clear_frame;
   logic [15:0] len;
   logic [15:0] len_full;
   logic [15:0] words_next;
   logic [7:0]  checksum;
   logic [7:0]  hi_byte;

   assign accept     = in_valid && in_ready;
   // Length as it will be once the low byte currently on the bus is latched.
   assign len_full   = {len[15:8], in_data};
   assign words_next = {4'd0, words_loaded} + 16'd1;

   // State-decoded outputs: the stream port and the core/status flags.
   always_comb begin
      in_ready = (state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK});
      done     = (state == DONE);
      error    = (state == ERROR);
      cpu_hold = !(state inside {IDLE, DONE});
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: every register in a clocked block is assigned with <=, so each
      // block reads the values from before the edge, whatever order the blocks run in.
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Next-state logic, and the strobe that starts a new frame.
   always_comb begin
      // NOTE: both outputs get a default before the case statement. Without
      // one, a path that leaves a variable unassigned would infer a latch.
      next_state  = state;
      clear_frame = 1'b0;
      unique case (state)
         IDLE, DONE, ERROR: begin
            if (start) begin
               next_state  = LEN_HI;
               clear_frame = 1'b1;
            end
         end
         LEN_HI: begin
            if (accept) next_state = LEN_LO;
         end
         LEN_LO: begin
            if (accept) begin
               if (len_full == 16'd0)                    next_state = CHECK;
               else if (len_full > 16'(MEMORY_DEPTH))    next_state = ERROR;
               else                                      next_state = DATA_HI;
            end
         end
         DATA_HI: begin
            if (accept) next_state = DATA_LO;
         end
         DATA_LO: begin
            if (accept) begin
               if (words_next == len) next_state = CHECK;
               else                   next_state = DATA_HI;
            end
         end
         CHECK: begin
            if (accept) next_state = (in_data == checksum) ? DONE : ERROR;
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath: length and high-byte capture, checksum, word counter and the registered write port.
   always_ff @(posedge clk) begin
      if (!rst) begin
         len          <= '0;
         checksum     <= '0;
         hi_byte      <= '0;
         words_loaded <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         mem_we <= 1'b0;
         if (clear_frame) begin
            len          <= '0;
            checksum     <= '0;
            words_loaded <= '0;
         end
         // The CHK byte is compared, never accumulated.
         if (accept && state != CHECK) checksum <= checksum ^ in_data;
         if (accept) begin
            unique case (state)
               LEN_HI:  len[15:8] <= in_data;
               LEN_LO:  len[7:0]  <= in_data;
               DATA_HI: hi_byte   <= in_data;
               DATA_LO: begin
                  mem_we       <= 1'b1;
                  mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
                  mem_wdata    <= {hi_byte, in_data};
                  words_loaded <= words_loaded + 12'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
// Stimulus pushes each expected memory write (address, data, due cycle) into a
// scoreboard queue. An independent monitor pops an entry on every mem_we and compares it.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [10:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [11:0] words_loaded;

   typedef struct {
      logic [10:0] addr;
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] frame_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   imem_loader #(.ADDR_WIDTH(11), .MEMORY_DEPTH(2048)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Cycle counter; it advances on every rising edge and is read only on falling edges.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: each write strobe must match the oldest expected write, including its cycle.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_write", 32'(mem_we), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("write_addr",  32'(mem_addr),  32'(e.addr));
            check("write_data",  32'(mem_wdata), 32'(e.data));
            check("write_cycle", 32'(cyc),       32'(e.due));
         end
      end
   end

   // Drive one byte from a falling edge and wait, within a bounded number of cycles, until it is accepted.
   task automatic send_byte(input logic [7:0] b, input bit is_lo,
                            input logic [10:0] addr, input logic [15:0] data);
      int waited;
      exp_t e;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check("ready_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
      end else begin
         if (is_lo) begin
            e.addr = addr;
            e.data = data;
            e.due  = cyc + 1;
            sb_q.push_back(e);
         end
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   // Send the bytes in frame_q, optionally with one idle cycle between bytes.
   task automatic send_frame(input bit gaps);
      int n;
      int len;
      n   = frame_q.size();
      len = (n >= 2) ? int'({frame_q[0], frame_q[1]}) : 0;
      for (int i = 0; i < n; i++) begin
         bit          is_lo;
         logic [10:0] addr;
         logic [15:0] data;
         is_lo = (i >= 3) && (i < 2 + 2 * len) && (((i - 2) % 2) == 1) && (len <= 2048);
         addr  = '0;
         data  = '0;
         if (is_lo) begin
            addr = 11'((i - 3) / 2);
            data = {frame_q[i-1], frame_q[i]};
         end
         send_byte(frame_q[i], is_lo, addr, data);
         if (gaps && i != n - 1) begin
            check("ready_in_gap", 32'(in_ready), 32'd1);
            @(negedge clk);
         end
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input string name);
      repeat (3) @(negedge clk);
      check(name, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic check_status(input string tag, input logic d, input logic e,
                               input logic h, input logic [11:0] w);
      check({tag, "_done"},  32'(done),         32'(d));
      check({tag, "_error"}, 32'(error),        32'(e));
      check({tag, "_hold"},  32'(cpu_hold),     32'(h));
      check({tag, "_words"}, 32'(words_loaded), 32'(w));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),     32'd0);
      check({tag, "_mem_we"},    32'(mem_we),       32'd0);
      check({tag, "_mem_addr"},  32'(mem_addr),     32'd0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata),    32'd0);
      check({tag, "_hold"},      32'(cpu_hold),     32'd0);
      check({tag, "_done"},      32'(done),         32'd0);
      check({tag, "_error"},     32'(error),        32'd0);
      check({tag, "_words"},     32'(words_loaded), 32'd0);
   endtask

   // Watchdog: stops the run if the stimulus ever stalls.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b1;
      @(negedge clk);

      // Test 1: three-word frame with a correct checksum.
      pulse_start();
      check("t1_hold_on_start", 32'(cpu_hold), 32'd1);
      check("t1_ready_on_start", 32'(in_ready), 32'd1);
      frame_q = '{8'h00, 8'h03, 8'h5A, 8'hFF, 8'h12, 8'h34, 8'h80, 8'h01, 8'h01};
      send_frame(1'b0);
      check_status("t1", 1'b1, 1'b0, 1'b0, 12'd3);
      drain("t1_drained");

      // Test 2: same frame with a bad checksum.
      pulse_start();
      check("t2_done_cleared", 32'(done), 32'd0);
      frame_q = '{8'h00, 8'h03, 8'h5A, 8'hFF, 8'h12, 8'h34, 8'h80, 8'h01, 8'h02};
      send_frame(1'b0);
      check_status("t2", 1'b0, 1'b1, 1'b1, 12'd3);
      drain("t2_drained");

      // Test 3a: zero-length frame.
      pulse_start();
      check("t3_error_cleared", 32'(error), 32'd0);
      frame_q = '{8'h00, 8'h00, 8'h00};
      send_frame(1'b0);
      check_status("t3a", 1'b1, 1'b0, 1'b0, 12'd0);
      // Test 3b: length 2049 is rejected right after LEN_LO.
      pulse_start();
      frame_q = '{8'h08, 8'h01};
      send_frame(1'b0);
      check_status("t3b", 1'b0, 1'b1, 1'b1, 12'd0);
      check("t3b_ready", 32'(in_ready), 32'd0);
      drain("t3_drained");

      // Test 4: frame 1 with in_valid toggling every cycle.
      pulse_start();
      frame_q = '{8'h00, 8'h03, 8'h5A, 8'hFF, 8'h12, 8'h34, 8'h80, 8'h01, 8'h01};
      send_frame(1'b1);
      check_status("t4", 1'b1, 1'b0, 1'b0, 12'd3);
      drain("t4_drained");

      // Test 5: reset after the first word, then a fresh full frame.
      pulse_start();
      frame_q = '{8'h00, 8'h03, 8'h5A, 8'hFF};
      send_frame(1'b0);
      check("t5_mid_wdata", 32'(mem_wdata), 32'h5AFF);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check_reset_values("t5_reset");
      drain("t5_no_more_writes");
      pulse_start();
      frame_q = '{8'h00, 8'h03, 8'h5A, 8'hFF, 8'h12, 8'h34, 8'h80, 8'h01, 8'h01};
      send_frame(1'b0);
      check_status("t5", 1'b1, 1'b0, 1'b0, 12'd3);
      drain("t5_drained");

      // Test 6: restart from DONE with a one-word frame.
      pulse_start();
      check("t6_done_drops", 32'(done), 32'd0);
      check("t6_hold_rises", 32'(cpu_hold), 32'd1);
      frame_q = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h67};
      send_frame(1'b0);
      check_status("t6", 1'b1, 1'b0, 1'b0, 12'd1);
      drain("t6_drained");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
